// File: rtl/uart_pkg.sv
// Shared types and helpers for the fabric-side UART receiver.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

  // Clock cycles per oversample tick, rounded to nearest.
  function automatic int baud_div(input int clk_hz, input int baud, input int os);
    int per_tick;
    per_tick = baud * os;
    return (clk_hz + per_tick / 2) / per_tick;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word fall-through FIFO; push while full succeeds only if a pop happens in the same cycle.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == (AW+1)'(DEPTH));
  assign count    = count_reg;
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  // Head is a don't-care while empty; forcing zero keeps the reset value clean.
  assign pop_data = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN defined) feeding a FWFT byte FIFO.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rxd,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                          parity_err
`endif
);
  localparam int DIV   = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);

  logic [1:0]       sync_reg;
  logic             rxd_s;
  logic [DIV_W-1:0] div_cnt_reg;
  logic             tick;
  rx_state_e        state_reg;
  logic [OS_W-1:0]  os_cnt_reg;
  logic [OS_W-1:0]  os_target;
  logic             sample;
  logic [2:0]       bit_cnt_reg;
  logic [7:0]       shift_reg;
  logic             frame_err_reg;
  logic             overrun_reg;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
`ifdef UART_RX_PARITY_EN
  logic             parity_bad_reg;
  logic             parity_err_reg;
`endif

  assign rxd_s = sync_reg[1];

  always_ff @(posedge clk) begin
    if (reset) sync_reg <= 2'b11;
    else       sync_reg <= {sync_reg[0], rxd};
  end

  assign tick = (div_cnt_reg == DIV_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || tick) div_cnt_reg <= '0;
    else               div_cnt_reg <= div_cnt_reg + DIV_W'(1);
  end

  // Start bit is checked mid-bit; every later bit one full bit period after that.
  assign os_target = (state_reg == ST_START) ? OS_W'(OVERSAMPLE / 2 - 1) : OS_W'(OVERSAMPLE - 1);
  assign sample    = tick && (os_cnt_reg == os_target);

`ifdef UART_RX_PARITY_EN
  assign push = (state_reg == ST_STOP) && sample && rxd_s && !parity_bad_reg;
`else
  assign push = (state_reg == ST_STOP) && sample && rxd_s;
`endif
  assign pop  = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      os_cnt_reg     <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_reg <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      frame_err_reg <= 1'b0;
      overrun_reg   <= push && fifo_full && !pop;
`ifdef UART_RX_PARITY_EN
      parity_err_reg <= 1'b0;
`endif
      if (tick) os_cnt_reg <= sample ? '0 : os_cnt_reg + OS_W'(1);
      case (state_reg)
        ST_IDLE: begin
          os_cnt_reg <= '0;
          if (!rxd_s) state_reg <= ST_START;
        end
        ST_START: begin
          bit_cnt_reg <= '0;
          if (sample) state_reg <= rxd_s ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (sample) begin
            shift_reg   <= {rxd_s, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_reg <= ST_PARITY;
`else
              state_reg <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (sample) begin
            parity_bad_reg <= rxd_s ^ (^shift_reg);
            state_reg      <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (sample) begin
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= parity_bad_reg;
`endif
            if (rxd_s) begin
              state_reg <= ST_IDLE;
            end else begin
              frame_err_reg <= 1'b1;
              state_reg     <= ST_WAIT_HIGH;
            end
          end
        end
        ST_WAIT_HIGH: begin
          if (rxd_s) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  sync_fifo_fwft #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (shift_reg),
    .pop       (pop),
    .pop_data  (m_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign m_valid   = !fifo_empty;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_reg;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core; scaled clock/baud keep frames short (64 cycles per bit).
module tb_uart_rx_core;
  localparam int CLK_HZ  = 3_840_000;
  localparam int BAUD    = 60_000;
  localparam int OS      = 16;
  localparam int DEPTH   = 16;
  localparam int BIT_CYC = (CLK_HZ / (BAUD * OS)) * OS;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [$clog2(DEPTH):0] fifo_count;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_core #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rxd        (rxd),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overrun    (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  int frame_err_seen = 0, exp_frame_err = 0;
  int overrun_seen = 0, exp_overrun = 0;
  int parity_err_seen = 0, exp_parity_err = 0;
  int ready_mode = 0;  // 0: always ready, 1: never ready, 2: random

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'b0;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted beat, counts error pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) frame_err_seen++;
      if (overrun)   overrun_seen++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) parity_err_seen++;
`endif
      if (m_valid && m_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_beat: got %02h, required no beat", m_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (m_data !== e) begin
            n_errors++;
            $display("FAIL rx_byte: got %02h, required %02h", m_data, e);
          end else begin
            $display("rx byte %02h ok", m_data);
          end
        end
      end
    end
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end else begin
      $display("check %s: %0d", name, act);
    end
  endtask

  task automatic drive_bit(input logic b);
    @(posedge clk);
    #1;
    rxd = b;
    repeat (BIT_CYC - 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop_bit);
    drive_bit(1'b1);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par_bit);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask
`endif

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || fifo_count != 0) && t < 4000) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_fifo_count"}, int'(fifo_count), 0);
  endtask

  initial begin
    logic [7:0] d;
    int occ;
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_m_valid", int'(m_valid), 0);
    check("reset_m_data", int'(m_data), 0);
    check("reset_fifo_count", int'(fifo_count), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_overrun", int'(overrun), 0);
    reset = 1'b0;
    repeat (BIT_CYC) @(posedge clk);

    // 1: single byte
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    wait_drain("t1");
    check("t1_frame_err", frame_err_seen, exp_frame_err);

    // 2: short glitch shorter than half a bit is ignored
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (12) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (2 * BIT_CYC) @(posedge clk);
    @(negedge clk);
    check("t2_fifo_count", int'(fifo_count), 0);
    check("t2_frame_err", frame_err_seen, exp_frame_err);

    // 3: bad stop bit, then a good frame
    send_frame(8'hA3, 1'b0);
    exp_frame_err++;
    repeat (BIT_CYC) @(posedge clk);
    @(negedge clk);
    check("t3_fifo_count", int'(fifo_count), 0);
    check("t3_frame_err", frame_err_seen, exp_frame_err);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_drain("t3");

    // 4: fill with consumer stalled, 17th byte overruns
    ready_mode = 1;
    occ = 0;
    for (int i = 0; i < 17; i++) begin
      if (occ < DEPTH) begin
        exp_q.push_back(8'(i));
        occ++;
      end else begin
        exp_overrun++;
      end
      send_frame(8'(i), 1'b1);
    end
    @(negedge clk);
    check("t4_fifo_count_full", int'(fifo_count), DEPTH);
    check("t4_overrun", overrun_seen, exp_overrun);
    check("t4_head", int'(m_data), 0);
    ready_mode = 0;
    wait_drain("t4");

    // 5: reset during data bit 4 discards the partial frame and the buffered byte
    ready_mode = 1;
    send_frame(8'h5A, 1'b1);
    @(negedge clk);
    check("t5_prefill", int'(fifo_count), 1);
    d = 8'h81;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    @(posedge clk);
    #1 rxd = d[4];
    repeat (BIT_CYC / 2) @(posedge clk);
    #1;
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("t5_reset_fifo_count", int'(fifo_count), 0);
    check("t5_reset_m_valid", int'(m_valid), 0);
    reset = 1'b0;
    ready_mode = 0;
    repeat (2 * BIT_CYC) @(posedge clk);
    @(negedge clk);
    check("t5_no_partial", int'(fifo_count), 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_drain("t5");

`ifdef UART_RX_PARITY_EN
    // 6: parity mismatch discards, correct parity delivers
    send_frame_par(8'h01, 1'b0);
    exp_parity_err++;
    @(negedge clk);
    check("t6_bad_parity_count", int'(fifo_count), 0);
    check("t6_parity_err", parity_err_seen, exp_parity_err);
    exp_q.push_back(8'h01);
    send_frame_par(8'h01, 1'b1);
    wait_drain("t6");
`endif

    // Random traffic with a random consumer and occasional bad stop bits
    ready_mode = 2;
    for (int n = 0; n < 30; n++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        exp_frame_err++;
        send_frame(d, 1'b0);
      end else begin
        exp_q.push_back(d);
        send_frame(d, 1'b1);
      end
      repeat ($urandom_range(0, BIT_CYC)) @(posedge clk);
    end
    wait_drain("rand");
    ready_mode = 0;

    check("final_frame_err", frame_err_seen, exp_frame_err);
    check("final_overrun", overrun_seen, exp_overrun);
    check("final_parity_err", parity_err_seen, exp_parity_err);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
